// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Lane indices map byte_cnt to big-endian byte positions within the word.
package ifu_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 8;
    localparam int unsigned INSTR_W        = BYTES_PER_WORD * LANE_W;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

    // Byte order within the word: lane 0 is the most significant byte.
    localparam logic [CNT_W-1:0] LANE_0 = CNT_W'(0);
    localparam logic [CNT_W-1:0] LANE_1 = CNT_W'(1);
    localparam logic [CNT_W-1:0] LANE_2 = CNT_W'(2);
    localparam logic [CNT_W-1:0] LANE_3 = CNT_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_word_assembler.sv
// Captures the first three bytes of a word into a staging register and
// loads the full big-endian word into the output register with the last byte.
module ifu_word_assembler
    import ifu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cap,
    input  logic               i_load,
    input  logic [CNT_W-1:0]   i_lane,
    input  logic [LANE_W-1:0]  i_byte,
    output logic [INSTR_W-1:0] o_instr
);

    logic [INSTR_W-LANE_W-1:0] r_part;
    logic [INSTR_W-1:0]        r_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_part  <= '0;
            r_instr <= '0;
        end else begin
            if (i_cap) begin
                case (i_lane)
                    LANE_0:  r_part[3*LANE_W-1:2*LANE_W] <= i_byte;
                    LANE_1:  r_part[2*LANE_W-1:LANE_W]   <= i_byte;
                    LANE_2:  r_part[LANE_W-1:0]          <= i_byte;
                    default: ;
                endcase
            end
            if (i_load) begin
                r_instr <= {r_part, i_byte};
            end
        end
    end

    assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Byte-serial instruction fetch: owns the PC, reads four bytes per word and
// hands the word to decode via valid/ready. IFU_ALIGN_CHECK_EN adds an alignment fault.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 10,
    parameter int unsigned        DATA_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               fault
);

    ifu_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_busy;
    logic              w_cap;
    logic              w_load;

    // A redirect or reset in the same cycle suppresses the byte capture.
    assign w_cap  = (r_state == ST_FETCH) && !rst && !redirect_valid;
    assign w_load = w_cap && (r_byte_cnt == LANE_3);

    ifu_word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .i_cap   (w_cap),
        .i_load  (w_load),
        .i_lane  (r_byte_cnt),
        .i_byte  (mem_rdata),
        .o_instr (instr)
    );

`ifdef IFU_ALIGN_CHECK_EN
    logic r_fault;
`endif

    // r_mem_addr always tracks r_pc + r_byte_cnt, updated alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_byte_cnt    <= '0;
            r_mem_addr    <= RESET_PC;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            r_fault       <= 1'b0;
`endif
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_mem_addr    <= redirect_pc;
            r_byte_cnt    <= '0;
            r_instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                r_state <= ST_FAULT;
                r_busy  <= 1'b0;
                r_fault <= 1'b1;
            end else begin
                r_state <= en ? ST_FETCH : ST_IDLE;
                r_busy  <= en;
                r_fault <= 1'b0;
            end
`else
            r_state       <= en ? ST_FETCH : ST_IDLE;
            r_busy        <= en;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state    <= ST_FETCH;
                        r_busy     <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (r_byte_cnt == LANE_3) begin
                        r_state       <= ST_HOLD;
                        r_busy        <= 1'b0;
                        r_byte_cnt    <= '0;
                        r_mem_addr    <= r_pc;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_instr_valid && instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= r_pc + ADDR_W'(BYTES_PER_WORD);
                        r_mem_addr    <= r_pc + ADDR_W'(BYTES_PER_WORD);
                        r_state       <= en ? ST_FETCH : ST_IDLE;
                        r_busy        <= en;
                    end
                end
                ST_FAULT: ;
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wr      = 1'b0;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
`ifdef IFU_ALIGN_CHECK_EN
    assign fault       = r_fault;
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected
// words, a negedge monitor pops and compares on every handshake.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic [9:0]  mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        fault;

    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem [0:1023];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_acc  = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_wr         (mem_wr),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .fault          (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [9:0] pc);
        exp_t e;
        e.instr = w;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        chk("mem_wr", 32'(mem_wr), 32'd0);
        if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("instr", instr, e.instr);
                chk("instr_pc", 32'(instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[10'h000] = 8'h20; mem[10'h001] = 8'h08; mem[10'h002] = 8'h00; mem[10'h003] = 8'h05;
        mem[10'h004] = 8'h8C; mem[10'h005] = 8'h09; mem[10'h006] = 8'h00; mem[10'h007] = 8'h04;
        mem[10'h100] = 8'h01; mem[10'h101] = 8'h09; mem[10'h102] = 8'h50; mem[10'h103] = 8'h20;
        mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
        mem[10'h3FE] = 8'hAC; mem[10'h3FF] = 8'h0A;

        rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        step(); step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // First word from reset PC, ready held high
        rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
        push(32'h20080005, 10'h000);
        step();
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_addr_seq", 32'(mem_addr), 32'(k));
            chk("t1_not_valid", 32'(instr_valid), 32'd0);
            step();
        end
        chk("t1_latency_valid", 32'(instr_valid), 32'd1);
        chk("t1_hold_addr", 32'(mem_addr), 32'h000);
        step();
        chk("t1_next_addr", 32'(mem_addr), 32'h004);
        chk("t1_valid_drop", 32'(instr_valid), 32'd0);

        // Back-pressure: word at 0x004 held for five cycles
        instr_ready = 1'b0;
        push(32'h8C090004, 10'h004);
        step(); step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            chk("t2_hold_instr", instr, 32'h8C090004);
            chk("t2_hold_pc", 32'(instr_pc), 32'h004);
            chk("t2_hold_addr", 32'(mem_addr), 32'h004);
            step();
        end
        instr_ready = 1'b1;
        step();
        chk("t2_valid_drop", 32'(instr_valid), 32'd0);
        chk("t2_next_addr", 32'(mem_addr), 32'h008);
        chk("t2_acc_once", 32'(n_acc), 32'd2);

        // Redirect to 0x100 while byte_cnt=2 of the word at 0x008
        step(); step();
        chk("t3_mid_addr", 32'(mem_addr), 32'h00A);
        redirect_valid = 1'b1; redirect_pc = 10'h100;
        push(32'h01095020, 10'h100);
        step();
        redirect_valid = 1'b0;
        chk("t3_redir_addr", 32'(mem_addr), 32'h100);
        chk("t3_redir_valid", 32'(instr_valid), 32'd0);
        step(); step(); step(); step();
        chk("t3_valid", 32'(instr_valid), 32'd1);
        en = 1'b0;
        step();
        chk("t3_idle_addr", 32'(mem_addr), 32'h104);
        chk("t3_idle_busy", 32'(busy), 32'd0);

`ifdef IFU_ALIGN_CHECK_EN
        // Unaligned redirect faults; aligned redirect recovers
        en = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h102;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("tf_fault", 32'(fault), 32'd1);
            chk("tf_no_valid", 32'(instr_valid), 32'd0);
            chk("tf_no_busy", 32'(busy), 32'd0);
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 10'h104;
        push(32'h11223344, 10'h104);
        step();
        redirect_valid = 1'b0;
        chk("tf_clear", 32'(fault), 32'd0);
        chk("tf_addr", 32'(mem_addr), 32'h104);
        step(); step(); step(); step();
        chk("tf_valid", 32'(instr_valid), 32'd1);
        en = 1'b0;
        step();
`endif

        // Unaligned redirect near the top of memory wraps byte addresses
        en = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h3FE;
`ifdef IFU_ALIGN_CHECK_EN
        redirect_pc = 10'h3FC;
        push({mem[10'h3FC], mem[10'h3FD], 8'hAC, 8'h0A}, 10'h3FC);
`else
        push(32'hAC0A2008, 10'h3FE);
`endif
        step();
        redirect_valid = 1'b0;
`ifndef IFU_ALIGN_CHECK_EN
        chk("t4_addr0", 32'(mem_addr), 32'h3FE); step();
        chk("t4_addr1", 32'(mem_addr), 32'h3FF); step();
        chk("t4_addr2", 32'(mem_addr), 32'h000); step();
        chk("t4_addr3", 32'(mem_addr), 32'h001); step();
`else
        step(); step(); step(); step();
`endif
        chk("t4_valid", 32'(instr_valid), 32'd1);
        en = 1'b0;
        step();
`ifndef IFU_ALIGN_CHECK_EN
        chk("t4_next_pc", 32'(mem_addr), 32'h002);

        // Redirect and handshake in the same cycle: word counts, pc follows redirect
        en = 1'b1; instr_ready = 1'b0;
        push(32'h00058C09, 10'h002);
        step(); step(); step(); step(); step();
        chk("t5_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h104;
        push(32'h11223344, 10'h104);
        step();
        redirect_valid = 1'b0;
        chk("t5_valid_drop", 32'(instr_valid), 32'd0);
        chk("t5_addr", 32'(mem_addr), 32'h104);
        step(); step(); step(); step();
        chk("t5_valid2", 32'(instr_valid), 32'd1);
        en = 1'b0;
        step();
        chk("t5_next_addr", 32'(mem_addr), 32'h108);
`else
        chk("t4_next_pc", 32'(mem_addr), 32'h000);
`endif

        // Reset in the middle of a fetch
        en = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'h000);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_instr", instr, 32'd0);
        rst = 1'b0;
        push(32'h20080005, 10'h000);
        step(); step(); step(); step(); step();
        chk("t6_valid2", 32'(instr_valid), 32'd1);
        en = 1'b0;
        step();
        step(); step();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef IFU_ALIGN_CHECK_EN
        chk("accepted_total", 32'(n_acc), 32'd6);
`else
        chk("accepted_total", 32'(n_acc), 32'd7);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
